// File: rtl/logic_unit_pkg.sv
// Shared types for the logic unit: operation codes and FSM states.
// Used by logic_unit (top, handshake/FSM) and logic_unit_core (op evaluation).
package logic_unit_pkg;

    // 3-bit operation code carried on in_op
    typedef enum logic [2:0] {
        OP_BAND = 3'd0,
        OP_BOR  = 3'd1,
        OP_BXOR = 3'd2,
        OP_LAND = 3'd3,
        OP_LOR  = 3'd4,
        OP_LNOT = 3'd5,
        OP_ACC  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    // Accumulate-burst FSM: IDLE between bursts, ACCUM while a burst is open
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational operation evaluation for the logic unit.
// Bitwise ops report flag = |bits; logical ops report bits = zero-extended flag.
// For ACC, acc_first selects a&b (first beat of a burst) instead of acc&a&b.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic             acc_first,
    output logic [WIDTH-1:0] bits,
    output logic             flag
);

    logic [WIDTH-1:0] vec;
    logic             truth;
    logic             is_logical;

    // Evaluate the selected operation as either a vector or a truth value
    always_comb begin
        vec        = '0;
        truth      = 1'b0;
        is_logical = 1'b0;
        case (op)
            OP_BAND: vec = a & b;
            OP_BOR:  vec = a | b;
            OP_BXOR: vec = a ^ b;
            OP_LAND: begin
                truth      = (|a) && (|b);
                is_logical = 1'b1;
            end
            OP_LOR: begin
                truth      = (|a) || (|b);
                is_logical = 1'b1;
            end
            OP_LNOT: begin
                truth      = !(|a);
                is_logical = 1'b1;
            end
            OP_ACC:  vec = acc_first ? (a & b) : (acc & a & b);
            default: begin
                // reserved op: all-zero result
                vec = '0;
            end
        endcase
    end

    // Fold the vector/truth pair into the shared bits/flag result
    always_comb begin
        bits = '0;
        flag = 1'b0;
        if (is_logical) begin
            bits[0] = truth;
            flag    = truth;
        end else begin
            bits = vec;
            flag = |vec;
        end
    end

endmodule

// File: rtl/logic_unit.sv
// Logic unit top: valid/ready handshake, one-cycle result register and the
// IDLE/ACCUM accumulate-burst FSM. Operation decoding lives in logic_unit_core.
// Optional feature macro: LOGIC_UNIT_CNT_EN adds the saturating xact_cnt output.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic             out_flag
`ifdef LOGIC_UNIT_CNT_EN
    ,
    output logic [CNT_W-1:0] xact_cnt
`endif
);

    state_e           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_bits_reg;
    logic             out_flag_reg;

    op_e              op;
    logic             accept;
    logic             acc_open;
    logic [WIDTH-1:0] core_bits;
    logic             core_flag;

    assign op       = op_e'(in_op);
    // A new beat may enter whenever the result slot is empty or being drained
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    // ACC beat that leaves the burst open (produces no output)
    assign acc_open = (op == OP_ACC) && !in_last;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op        (op),
        .a         (in_a),
        .b         (in_b),
        .acc       (acc_reg),
        .acc_first (state_reg == ST_IDLE),
        .bits      (core_bits),
        .flag      (core_flag)
    );

    // FSM, accumulator and registered result with output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '1;
            out_valid_reg <= 1'b0;
            out_bits_reg  <= '0;
            out_flag_reg  <= 1'b0;
        end else if (accept) begin
            if (acc_open) begin
                // Burst continues: fold this beat into acc, no output beat.
                // Any previous result was handshaken on this same edge.
                state_reg     <= ST_ACCUM;
                acc_reg       <= core_bits;
                out_valid_reg <= 1'b0;
            end else begin
                // Closing ACC beat or any other op (which also aborts a burst)
                state_reg     <= ST_IDLE;
                acc_reg       <= '1;
                out_valid_reg <= 1'b1;
                out_bits_reg  <= core_bits;
                out_flag_reg  <= core_flag;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bits  = out_bits_reg;
    assign out_flag  = out_flag_reg;

`ifdef LOGIC_UNIT_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Count completed output handshakes, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (out_valid_reg && out_ready && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign xact_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit (WIDTH = 2). Expected results are pushed
// to a scoreboard queue when a beat is accepted and popped by the output monitor.
// Define LOGIC_UNIT_CNT_EN to also exercise the saturating transaction counter.
module tb_logic_unit;

    localparam int W     = 2;
    localparam int CNT_W = 2;

    typedef struct {
        logic [W-1:0] bits;
        logic         flag;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_bits;
    logic         out_flag;
`ifdef LOGIC_UNIT_CNT_EN
    logic [CNT_W-1:0] xact_cnt;
`endif

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   hs_count     = 0;
    int   cyc          = 0;
    exp_t exp_q[$];

    logic_unit #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_flag  (out_flag)
`ifdef LOGIC_UNIT_CNT_EN
        ,
        .xact_cnt  (xact_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference for a single beat; acc is the running AND value
    function automatic logic [W:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] acc);
        logic [W-1:0] v;
        logic         t;
        v = '0;
        t = 1'b0;
        case (op)
            3'd0: begin v = a & b;       t = (v != 0); end
            3'd1: begin v = a | b;       t = (v != 0); end
            3'd2: begin v = a ^ b;       t = (v != 0); end
            3'd3: begin t = (a != 0) && (b != 0); v = W'(t); end
            3'd4: begin t = (a != 0) || (b != 0); v = W'(t); end
            3'd5: begin t = (a == 0);    v = W'(t); end
            3'd6: begin v = acc & a & b; t = (v != 0); end
            default: begin v = '0; t = 1'b0; end
        endcase
        return {t, v};
    endfunction

    // Output monitor: every handshake pops and checks one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            hs_count++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_output: got bits=%b flag=%b, want no output", out_bits, out_flag);
            end else begin
                e = exp_q.pop_front();
                if (out_bits !== e.bits || out_flag !== e.flag) begin
                    tests_failed++;
                    $display("FAIL %s: got bits=%b flag=%b, want bits=%b flag=%b",
                             e.name, out_bits, out_flag, e.bits, e.flag);
                end else begin
                    $display("[TB] %s: bits=%b flag=%b ok", e.name, out_bits, out_flag);
                end
            end
        end
    end

    // Offer one beat and hold it until accepted; expected result queued on acceptance.
    // Starts and ends 1 time unit after a rising edge.
    task automatic send(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic last, input bit emits,
                        input logic [W-1:0] eb, input logic ef);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_accept: in_ready=0 after 50 cycles, want 1", name);
        end else if (emits) begin
            e.bits = eb;
            e.flag = ef;
            e.name = name;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard has drained, then align to edge+1
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0 || out_bits !== '0 || out_flag !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got valid=%b bits=%b flag=%b, want 0 00 0",
                         out_valid, out_bits, out_flag);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_band();
        send("band_11_01", 3'd0, 2'b11, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL band_latency: out_valid=%b one cycle after accept, want 1", out_valid);
        end
        wait_drain();
    endtask

    task automatic test_land();
        send("land_00_11", 3'd3, 2'b00, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0);
        send("land_11_10", 3'd3, 2'b11, 2'b10, 1'b0, 1'b1, 2'b01, 1'b1);
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL land_drain: %0d results outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_all_ops();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [W:0]   r;
        // each op at least once, then random picks
        for (int i = 0; i < 24; i++) begin
            op = (i < 8) ? 3'(i) : 3'($urandom_range(0, 7));
            a  = W'($urandom_range(0, 3));
            b  = W'($urandom_range(0, 3));
            r  = ref_result(op, a, b, '1);
            send($sformatf("op%0d_%b_%b", op, a, b), op, a, b, 1'b1, 1'b1, r[W-1:0], r[W]);
        end
        wait_drain();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL ops_drain: %0d results outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_acc();
        int hs0;
        hs0 = hs_count;
        send("acc_b1", 3'd6, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL acc_beat1_valid: out_valid=%b, want 0", out_valid);
        end
        send("acc_b2", 3'd6, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL acc_beat2_valid: out_valid=%b, want 0", out_valid);
        end
        send("acc_last", 3'd6, 2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL acc_last_valid: out_valid=%b, want 1", out_valid);
        end
        wait_drain();
        tests_run++;
        if (hs_count - hs0 != 1) begin
            tests_failed++;
            $display("FAIL acc_outputs: got %0d handshakes, want 1", hs_count - hs0);
        end
    endtask

    task automatic test_abort();
        send("abort_acc", 3'd6, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        send("abort_bor", 3'd1, 2'b00, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1);
        // burst state was discarded, so this ACC restarts from a&b
        send("abort_acc_new", 3'd6, 2'b11, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1);
        wait_drain();
    endtask

    task automatic test_stall();
        int hs0;
        out_ready = 1'b0;
        send("stall_bor", 3'd1, 2'b11, 2'b10, 1'b0, 1'b1, 2'b11, 1'b1);
        hs0 = hs_count;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_bits !== 2'b11 || out_flag !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold: got valid=%b bits=%b flag=%b in_ready=%b, want 1 11 1 0",
                         out_valid, out_bits, out_flag, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (hs_count - hs0 != 1) begin
            tests_failed++;
            $display("FAIL stall_release: got %0d handshakes, want 1", hs_count - hs0);
        end
    endtask

    task automatic test_reset_mid();
        send("rmid_acc", 3'd6, 2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_in_reset: out_valid=%b, want 0", out_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send("rmid_acc_after", 3'd6, 2'b11, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        send("rstall_band", 3'd0, 2'b11, 2'b11, 1'b0, 1'b1, 2'b11, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstall_flushed: out_valid=%b after reset, want 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int           c0;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [W:0]   r;
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = W'($urandom_range(0, 3));
            b  = W'($urandom_range(0, 3));
            r  = ref_result(op, a, b, '1);
            send($sformatf("b2b%0d_op%0d", i, op), op, a, b, 1'b1, 1'b1, r[W-1:0], r[W]);
        end
        tests_run++;
        if (cyc - c0 != 8) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d cycles for 8 beats, want 8", cyc - c0);
        end
        wait_drain();
    endtask

`ifdef LOGIC_UNIT_CNT_EN
    task automatic test_counter();
        test_reset();
        tests_run++;
        if (xact_cnt !== '0) begin
            tests_failed++;
            $display("FAIL cnt_reset: xact_cnt=%0d, want 0", xact_cnt);
        end
        send("cnt_b0", 3'd0, 2'b11, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1);
        wait_drain();
        tests_run++;
        if (xact_cnt !== 2'd1) begin
            tests_failed++;
            $display("FAIL cnt_one: xact_cnt=%0d, want 1", xact_cnt);
        end
        for (int i = 1; i < 5; i++) begin
            send($sformatf("cnt_b%0d", i), 3'd1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1);
        end
        wait_drain();
        tests_run++;
        if (xact_cnt !== 2'd3) begin
            tests_failed++;
            $display("FAIL cnt_saturate: xact_cnt=%0d, want 3", xact_cnt);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2;
        test_reset();
        test_band();
        test_land();
        test_all_ops();
        test_acc();
        test_abort();
        test_stall();
        test_reset_mid();
        test_reset_stall();
        test_back_to_back();
`ifdef LOGIC_UNIT_CNT_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, want completion");
        $fatal(1, "timeout");
    end

endmodule
